// File: rtl/apb_fsm_controller_if.sv
// Bus bundle between the AHB side, the APB controller and the APB slaves.
// The controller connects through the slave modport; the AHB master and the slaves use master.
interface apb_fsm_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic [ADDR_W-1:0] Haddr;
    logic              Hwrite;
    logic [DATA_W-1:0] Hwdata;
    logic [DATA_W-1:0] Prdata;
    logic              Hreadyout;
    logic [DATA_W-1:0] Hrdata;
    logic [2:0]        Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;

    modport slave (
        input  valid, Haddr, Hwrite, Hwdata, Prdata,
        output Hreadyout, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
    );

    modport master (
        output valid, Haddr, Hwrite, Hwdata, Prdata,
        input  Hreadyout, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_fsm_controller.sv
// Sequences one AHB transfer at a time onto a three-slave APB window.
// Every output is a flop whose next value is derived from the next state.
module apb_fsm_controller #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                REGION_BITS = 24
) (
    input logic                  Hclk,
    input logic                  Hreset,
    apb_fsm_controller_if.slave  bus
);
    localparam int HI_LSB = REGION_BITS + 2;

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        READ,
        RENABLE,
        WRITE,
        WENABLE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              hreadyout_q, hreadyout_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic [2:0]        pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    logic [1:0] req_idx;
    logic       hit;
    logic       accept;
    logic [2:0] sel_d;

    assign req_idx = bus.Haddr[REGION_BITS+1:REGION_BITS];
    assign hit     = (bus.Haddr[ADDR_W-1:HI_LSB] == BASE_ADDR[ADDR_W-1:HI_LSB])
                     && (req_idx != 2'd3);
    assign accept  = bus.valid && hreadyout_q && hit && (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        hrdata_d = hrdata_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = req_idx;
                    addr_d  = bus.Haddr;
                    state_d = bus.Hwrite ? WWAIT : READ;
                end
            end
            WWAIT: begin
                // Write data arrives in the AHB data phase, one cycle after the address.
                pwdata_d = bus.Hwdata;
                state_d  = WRITE;
            end
            READ:    state_d = RENABLE;
            RENABLE: begin
                hrdata_d = bus.Prdata;
                state_d  = IDLE;
            end
            WRITE:   state_d = WENABLE;
            WENABLE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sel_d       = 3'b001 << idx_d;
        hreadyout_d = (state_d == IDLE);
        pselx_d     = '0;
        penable_d   = 1'b0;

        // SETUP states last one cycle, so address/direction load only on entry.
        unique case (state_d)
            READ: begin
                pselx_d  = sel_d;
                paddr_d  = addr_d;
                pwrite_d = 1'b0;
            end
            WRITE: begin
                pselx_d  = sel_d;
                paddr_d  = addr_d;
                pwrite_d = 1'b1;
            end
            RENABLE, WENABLE: begin
                pselx_d   = sel_d;
                penable_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            hreadyout_q <= 1'b1;
            hrdata_q    <= '0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            hreadyout_q <= hreadyout_d;
            hrdata_q    <= hrdata_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign bus.Hreadyout = hreadyout_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_fsm_controller.sv
// Random and directed AHB transfers; expected APB transactions are queued at issue
// and checked by an independent monitor as they appear on the APB side.
module tb_apb_fsm_controller;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic Hclk = 1'b0;
    logic Hreset = 1'b0;

    apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_fsm_controller #(
        .ADDR_W(32),
        .DATA_W(32),
        .BASE_ADDR(32'h8000_0000),
        .REGION_BITS(24)
    ) dut (
        .Hclk(Hclk),
        .Hreset(Hreset),
        .bus(bus)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  sel;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_hrdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Window is three consecutive 16 MB regions starting at BASE.
    function automatic bit model_hit(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'h0300_0000);
    endfunction

    function automatic logic [2:0] model_sel(input logic [31:0] a);
        return 3'(1 << ((a - BASE) / 32'h0100_0000));
    endfunction

    // Monitor: APB phase checks and completion checks.
    logic        prev_ready = 1'b1;
    logic [2:0]  prev_psel = '0;
    logic        prev_pen = 1'b0;
    logic [31:0] prev_paddr = '0;
    logic [31:0] prev_pwdata = '0;
    int          low_cnt = 0;
    txn_t        cur;
    bit          cur_valid = 1'b0;

    always @(negedge Hclk) begin
        if (Hreset) begin
            prev_ready = 1'b1;
            prev_psel  = '0;
            prev_pen   = 1'b0;
            low_cnt    = 0;
            cur_valid  = 1'b0;
        end else begin
            if (bus.Penable) begin
                if (exp_q.size() == 0) begin
                    fail_evt("unexpected_access");
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    chk("access_pselx", 32'(bus.Pselx), 32'(cur.sel));
                    chk("setup_pselx", 32'(prev_psel), 32'(cur.sel));
                    chk("setup_penable", 32'(prev_pen), 32'd0);
                    chk("access_pwrite", 32'(bus.Pwrite), 32'(cur.wr));
                    chk("access_paddr", bus.Paddr, cur.addr);
                    chk("setup_paddr", prev_paddr, cur.addr);
                    if (cur.wr) begin
                        chk("access_pwdata", bus.Pwdata, cur.data);
                        chk("setup_pwdata", prev_pwdata, cur.data);
                    end
                end
            end else if (bus.Pselx != 3'b000 && exp_q.size() == 0) begin
                chk("spurious_setup", 32'(bus.Pselx), 32'd0);
            end

            if (!bus.Hreadyout) begin
                low_cnt++;
            end else if (!prev_ready) begin
                if (!cur_valid) begin
                    fail_evt("completion_without_access");
                end else begin
                    chk("stall_cycles", 32'(low_cnt), cur.wr ? 32'd3 : 32'd2);
                    if (!cur.wr) exp_hrdata = cur.data;
                    chk("completion_hrdata", bus.Hrdata, exp_hrdata);
                end
                low_cnt   = 0;
                cur_valid = 1'b0;
            end

            prev_ready  = bus.Hreadyout;
            prev_psel   = bus.Pselx;
            prev_pen    = bus.Penable;
            prev_paddr  = bus.Paddr;
            prev_pwdata = bus.Pwdata;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!bus.Hreadyout && n < 20) begin
            @(negedge Hclk);
            n++;
        end
        if (!bus.Hreadyout) fail_evt("hreadyout_timeout");
    endtask

    // Called at a negedge with the controller idle; returns at a negedge, idle again.
    task automatic issue(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
        bus.valid  = 1'b1;
        bus.Haddr  = addr;
        bus.Hwrite = wr;
        bus.Prdata = rdata;
        if (model_hit(addr))
            exp_q.push_back('{wr: wr, addr: addr, sel: model_sel(addr), data: wr ? wdata : rdata});
        @(negedge Hclk);
        bus.valid  = 1'b0;
        bus.Hwdata = wdata;
        if (!model_hit(addr)) begin
            chk("miss_hreadyout", 32'(bus.Hreadyout), 32'd1);
            chk("miss_pselx", 32'(bus.Pselx), 32'd0);
            chk("miss_hrdata", bus.Hrdata, exp_hrdata);
        end else begin
            chk("accept_stall", 32'(bus.Hreadyout), 32'd0);
        end
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hreadyout"}, 32'(bus.Hreadyout), 32'd1);
        chk({tag, "_pselx"}, 32'(bus.Pselx), 32'd0);
        chk({tag, "_penable"}, 32'(bus.Penable), 32'd0);
        chk({tag, "_pwrite"}, 32'(bus.Pwrite), 32'd0);
        chk({tag, "_paddr"}, bus.Paddr, 32'd0);
        chk({tag, "_pwdata"}, bus.Pwdata, 32'd0);
        chk({tag, "_hrdata"}, bus.Hrdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          wr;

        bus.valid  = 1'b0;
        bus.Haddr  = '0;
        bus.Hwrite = 1'b0;
        bus.Hwdata = '0;
        bus.Prdata = '0;

        #2 Hreset = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge Hclk);
        @(negedge Hclk);
        #2 Hreset = 1'b0;
        @(negedge Hclk);

        issue(1'b0, 32'h8100_0010, 32'h0, 32'h0000_00A5);
        chk("dir_read_hrdata", bus.Hrdata, 32'h0000_00A5);

        issue(1'b1, 32'h8200_0004, 32'hDEAD_BEEF, 32'h1234_5678);
        chk("dir_write_hrdata_kept", bus.Hrdata, 32'h0000_00A5);
        chk("dir_write_pwdata_held", bus.Pwdata, 32'hDEAD_BEEF);

        issue(1'b0, 32'h8300_0000, 32'h0, 32'hFFFF_FFFF);
        issue(1'b1, 32'h9000_0000, 32'h0BAD_F00D, 32'h0);

        // Write followed by a read held on valid through the write stall.
        bus.valid  = 1'b1;
        bus.Haddr  = 32'h8000_0000;
        bus.Hwrite = 1'b1;
        exp_q.push_back('{wr: 1'b1, addr: 32'h8000_0000, sel: 3'b001, data: 32'hCAFE_0001});
        @(negedge Hclk);
        bus.Hwdata = 32'hCAFE_0001;
        bus.Hwrite = 1'b0;
        bus.Prdata = 32'h5A5A_0002;
        exp_q.push_back('{wr: 1'b0, addr: 32'h8000_0000, sel: 3'b001, data: 32'h5A5A_0002});
        wait_idle();
        @(negedge Hclk);
        bus.valid = 1'b0;
        chk("b2b_read_accepted_first_ready", 32'(bus.Hreadyout), 32'd0);
        chk("b2b_read_setup_pselx", 32'(bus.Pselx), 32'b001);
        wait_idle();
        chk("b2b_read_hrdata", bus.Hrdata, 32'h5A5A_0002);

        // Reset while in the ACCESS phase of a read.
        bus.valid  = 1'b1;
        bus.Haddr  = 32'h8100_0020;
        bus.Hwrite = 1'b0;
        bus.Prdata = 32'h7777_7777;
        exp_q.push_back('{wr: 1'b0, addr: 32'h8100_0020, sel: 3'b010, data: 32'h7777_7777});
        @(negedge Hclk);
        bus.valid = 1'b0;
        @(negedge Hclk);
        chk("pre_reset_penable", 32'(bus.Penable), 32'd1);
        #2 Hreset = 1'b1;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        exp_hrdata = '0;
        @(negedge Hclk);
        #2 Hreset = 1'b0;
        @(negedge Hclk);
        issue(1'b0, 32'h8100_0020, 32'h0, 32'h0000_1357);
        chk("post_reset_read_hrdata", bus.Hrdata, 32'h0000_1357);

        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0, 1, 2: a = BASE + ($urandom_range(0, 2) << 24) + ($urandom & 32'h00FF_FFFC);
                3:       a = 32'h8300_0000 | ($urandom & 32'h00FF_FFFC);
                default: a = $urandom;
            endcase
            issue(wr, a, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge Hclk);
        end

        repeat (4) @(negedge Hclk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
